// File: rtl/commit_ctrl_pkg.sv
// rtl/commit_ctrl_pkg.sv - head type and FSM state encodings for the commit sequencer
package commit_ctrl_pkg;

  typedef enum logic [1:0] {
    HT_REG    = 2'd0,
    HT_STORE  = 2'd1,
    HT_BRANCH = 2'd2,
    HT_RSV    = 2'd3
  } head_type_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_ST = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam int FLUSH_CNT_W = 4;

  function automatic logic is_store(input logic [1:0] ty);
    return head_type_e'(ty) == HT_STORE;
  endfunction

endpackage

// File: rtl/commit_ctrl_if.sv
// rtl/commit_ctrl_if.sv - ROB head, RF commit, store handshake and redirect signals
interface commit_ctrl_if #(
  parameter int ROB_ID_W = 32
);
  logic                head_valid;
  logic                head_ready;
  logic [1:0]          head_type;
  logic [4:0]          head_rd;
  logic [ROB_ID_W-1:0] head_rob_id;
  logic [31:0]         head_val;
  logic                head_mispred;
  logic [31:0]         head_target;
  logic                rob_pop;

  logic                ROB_cmt_flag;
  logic [4:0]          ROB_cmt_rd;
  logic [ROB_ID_W-1:0] ROB_cmt_rob_id;
  logic [31:0]         ROB_cmt_val;

  logic                st_cmt_req;
  logic [ROB_ID_W-1:0] st_cmt_rob_id;
  logic                st_cmt_ack;

  logic                jump_wrong_stall;
  logic                redirect_flag;
  logic [31:0]         redirect_pc;
  logic [31:0]         cmt_cnt;

  modport master (
    input  head_valid, head_ready, head_type, head_rd, head_rob_id,
           head_val, head_mispred, head_target, st_cmt_ack,
    output rob_pop, ROB_cmt_flag, ROB_cmt_rd, ROB_cmt_rob_id, ROB_cmt_val,
           st_cmt_req, st_cmt_rob_id, jump_wrong_stall, redirect_flag,
           redirect_pc, cmt_cnt
  );

  modport slave (
    output head_valid, head_ready, head_type, head_rd, head_rob_id,
           head_val, head_mispred, head_target, st_cmt_ack,
    input  rob_pop, ROB_cmt_flag, ROB_cmt_rd, ROB_cmt_rob_id, ROB_cmt_val,
           st_cmt_req, st_cmt_rob_id, jump_wrong_stall, redirect_flag,
           redirect_pc, cmt_cnt
  );
endinterface

// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - in-order retirement of the ROB head into RF, LSB and PC redirect
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int ROB_ID_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  commit_ctrl_if.master bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYC);

  state_e                 state, state_nx;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nx;

  logic                cmt_flag_q, cmt_flag_nx;
  logic [4:0]          cmt_rd_q, cmt_rd_nx;
  logic [ROB_ID_W-1:0] cmt_id_q, cmt_id_nx;
  logic [31:0]         cmt_val_q, cmt_val_nx;
  logic                st_req_q, st_req_nx;
  logic [ROB_ID_W-1:0] st_id_q, st_id_nx;
  logic                jws_q, jws_nx;
  logic                redir_q, redir_nx;
  logic [31:0]         redir_pc_q, redir_pc_nx;
  logic [31:0]         cnt_q;
  logic                pop;
  logic                head_go;
  head_type_e          head_ht;

  assign head_go = bus.head_valid && bus.head_ready;
  assign head_ht = head_type_e'(bus.head_type);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else if (rdy) begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
    end
  end

  // Strobes default low so they never linger; data fields hold until overwritten.
  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    pop          = 1'b0;
    cmt_flag_nx  = 1'b0;
    cmt_rd_nx    = cmt_rd_q;
    cmt_id_nx    = cmt_id_q;
    cmt_val_nx   = cmt_val_q;
    st_req_nx    = st_req_q;
    st_id_nx     = st_id_q;
    jws_nx       = jws_q;
    redir_nx     = 1'b0;
    redir_pc_nx  = redir_pc_q;
    case (state)
      RUN: begin
        st_req_nx = 1'b0;
        if (head_go) begin
          if (is_store(bus.head_type)) begin
            st_req_nx = 1'b1;
            st_id_nx  = bus.head_rob_id;
            state_nx  = WAIT_ST;
          end else begin
            pop         = 1'b1;
            cmt_flag_nx = 1'b1;
            cmt_rd_nx   = bus.head_rd;
            cmt_id_nx   = bus.head_rob_id;
            cmt_val_nx  = bus.head_val;
            if (head_ht == HT_BRANCH && bus.head_mispred) begin
              redir_nx     = 1'b1;
              redir_pc_nx  = bus.head_target;
              jws_nx       = 1'b1;
              flush_cnt_nx = FLUSH_INIT;
              state_nx     = FLUSH;
            end
          end
        end
      end
      WAIT_ST: begin
        if (bus.st_cmt_ack) begin
          pop       = 1'b1;
          st_req_nx = 1'b0;
          state_nx  = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt <= FLUSH_CNT_W'(1)) begin
          flush_cnt_nx = '0;
          jws_nx       = 1'b0;
          state_nx     = RUN;
        end else begin
          flush_cnt_nx = flush_cnt - FLUSH_CNT_W'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmt_flag_q <= 1'b0;
      cmt_rd_q   <= '0;
      cmt_id_q   <= '0;
      cmt_val_q  <= '0;
      st_req_q   <= 1'b0;
      st_id_q    <= '0;
      jws_q      <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else if (rdy) begin
      cmt_flag_q <= cmt_flag_nx;
      cmt_rd_q   <= cmt_rd_nx;
      cmt_id_q   <= cmt_id_nx;
      cmt_val_q  <= cmt_val_nx;
      st_req_q   <= st_req_nx;
      st_id_q    <= st_id_nx;
      jws_q      <= jws_nx;
      redir_q    <= redir_nx;
      redir_pc_q <= redir_pc_nx;
      if (pop)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  // rst gates the pop so every output reads 0 while reset is held.
  assign bus.rob_pop          = pop && rdy && rst;
  assign bus.ROB_cmt_flag     = cmt_flag_q;
  assign bus.ROB_cmt_rd       = cmt_rd_q;
  assign bus.ROB_cmt_rob_id   = cmt_id_q;
  assign bus.ROB_cmt_val      = cmt_val_q;
  assign bus.st_cmt_req       = st_req_q;
  assign bus.st_cmt_rob_id    = st_id_q;
  assign bus.jump_wrong_stall = jws_q;
  assign bus.redirect_flag    = redir_q;
  assign bus.redirect_pc      = redir_pc_q;
  assign bus.cmt_cnt          = cnt_q;

endmodule
